// File: rtl/acia_rx_fifo_pkg.sv
// Shared ACIA receive-path definitions: default geometry, bus register map
// and status register layout.
package acia_rx_fifo_pkg;

    localparam int ACIA_AW      = 4;
    localparam int ACIA_IRQ_THR = 1;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int ST_AVAIL = 0;
    localparam int ST_OVR   = 1;
    localparam int ST_FERR  = 2;
    localparam int ST_IRQ   = 7;

    // Assembles the status byte the 6502 bus interface presents at REG_STATUS.
    function automatic logic [7:0] status_byte(input logic avail, input logic ovr,
                                               input logic ferr, input logic irq);
        logic [7:0] s;
        s           = 8'h00;
        s[ST_AVAIL] = avail;
        s[ST_OVR]   = ovr;
        s[ST_FERR]  = ferr;
        s[ST_IRQ]   = irq;
        return s;
    endfunction

endpackage

// File: rtl/acia_rx_fifo_if.sv
// Bundle between the ACIA receiver/bus interface and the receive buffer.
// The slave side is the buffer itself; the master side drives receiver and CPU strobes.
interface acia_rx_fifo_if
    import acia_rx_fifo_pkg::*;
#(
    parameter int AW = ACIA_AW
) ();

    logic [7:0]  rx_dat;
    logic        rx_stb;
    logic        rx_err;
    logic        rd;
    logic        clr_err;
    logic [7:0]  rd_dat;
    logic        rx_avail;
    logic [AW:0] rx_level;
    logic        rx_ovr;
    logic        rx_ferr;
    logic        rx_irq;

    modport master (
        output rx_dat, rx_stb, rx_err, rd, clr_err,
        input  rd_dat, rx_avail, rx_level, rx_ovr, rx_ferr, rx_irq
    );

    modport slave (
        input  rx_dat, rx_stb, rx_err, rd, clr_err,
        output rd_dat, rx_avail, rx_level, rx_ovr, rx_ferr, rx_irq
    );

endinterface

// File: rtl/acia_rx_fifo_fifo.sv
// Generic show-ahead synchronous byte FIFO, shared by the ACIA receive and transmit paths.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module acia_fifo
    import acia_rx_fifo_pkg::*;
#(
    parameter int AW = ACIA_AW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_LVL);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign level   = count;
    assign dout    = empty ? 8'h00 : mem[rd_ptr];

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push && !reset)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/acia_rx_fifo.sv
// ACIA receive buffer: edge-detects receiver strobes into a FIFO, keeps sticky
// overrun/framing flags and drives the CPU interrupt request.
module acia_rx_fifo
    import acia_rx_fifo_pkg::*;
#(
    parameter int AW      = ACIA_AW,
    parameter int IRQ_THR = ACIA_IRQ_THR
) (
    input  logic          clk,
    input  logic          reset,
    acia_rx_fifo_if.slave bus
);

    localparam logic [AW:0] THR_LVL = (AW + 1)'(IRQ_THR);

    logic        stb_d;
    logic        err_d;
    logic        push_ev;
    logic        ferr_ev;
    logic        ovr_ev;
    logic        full;
    logic        empty;
    logic [AW:0] level;
    logic [7:0]  head;
    logic        ovr;
    logic        ferr;

    assign push_ev = bus.rx_stb & ~stb_d;
    assign ferr_ev = bus.rx_err & ~err_d;
    // A pop on the same edge frees the slot, so only an unrelieved full push overruns.
    assign ovr_ev  = push_ev & full & ~bus.rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            stb_d <= 1'b0;
            err_d <= 1'b0;
        end else begin
            stb_d <= bus.rx_stb;
            err_d <= bus.rx_err;
        end
    end

    // Sticky flags: a new event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (ovr_ev)
                ovr <= 1'b1;
            else if (bus.clr_err)
                ovr <= 1'b0;
            if (ferr_ev)
                ferr <= 1'b1;
            else if (bus.clr_err)
                ferr <= 1'b0;
        end
    end

    acia_fifo #(
        .AW(AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ev),
        .pop   (bus.rd),
        .din   (bus.rx_dat),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign bus.rd_dat   = head;
    assign bus.rx_avail = ~empty;
    assign bus.rx_level = level;
    assign bus.rx_ovr   = ovr;
    assign bus.rx_ferr  = ferr;
    assign bus.rx_irq   = (level >= THR_LVL) | ovr | ferr;

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Directed bench for acia_rx_fifo: two instances (interrupt threshold 1 and 4)
// with scoreboard queues holding the bytes each FIFO should return.
module tb_acia_rx_fifo;

    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    acia_rx_fifo_if #(.AW(AW)) bus_a ();
    acia_rx_fifo_if #(.AW(AW)) bus_b ();

    acia_rx_fifo #(.AW(AW), .IRQ_THR(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    acia_rx_fifo #(.AW(AW), .IRQ_THR(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    // Inputs change at a falling edge; outputs are sampled at the next falling edge.
    task automatic cycle(input int n = 1);
        for (int i = 0; i < n; i++)
            @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus_a(input logic [7:0] b, input logic accepted);
        bus_a.rx_dat = b;
        bus_a.rx_stb = 1'b1;
        if (accepted)
            q_a.push_back(b);
        cycle();
        bus_a.rx_stb = 1'b0;
        cycle();
    endtask

    task automatic apply_stimulus_b(input logic [7:0] b);
        bus_b.rx_dat = b;
        bus_b.rx_stb = 1'b1;
        q_b.push_back(b);
        cycle();
        bus_b.rx_stb = 1'b0;
        cycle();
    endtask

    task automatic pop_a(input string tag);
        logic [7:0] e;
        check_output({tag, "_sb_nonempty"}, 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) begin
            e = q_a.pop_front();
            check_output(tag, bus_a.rd_dat, e);
        end
        bus_a.rd = 1'b1;
        cycle();
        bus_a.rd = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_a_rd_dat"}, bus_a.rd_dat,   8'h00);
        check_output({tag, "_a_avail"},  bus_a.rx_avail, 1'b0);
        check_output({tag, "_a_level"},  bus_a.rx_level, 0);
        check_output({tag, "_a_ovr"},    bus_a.rx_ovr,   1'b0);
        check_output({tag, "_a_ferr"},   bus_a.rx_ferr,  1'b0);
        check_output({tag, "_a_irq"},    bus_a.rx_irq,   1'b0);
        check_output({tag, "_b_rd_dat"}, bus_b.rd_dat,   8'h00);
        check_output({tag, "_b_avail"},  bus_b.rx_avail, 1'b0);
        check_output({tag, "_b_level"},  bus_b.rx_level, 0);
        check_output({tag, "_b_irq"},    bus_b.rx_irq,   1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        bus_a.rx_dat  = 8'h00;
        bus_a.rx_stb  = 1'b0;
        bus_a.rx_err  = 1'b0;
        bus_a.rd      = 1'b0;
        bus_a.clr_err = 1'b0;
        bus_b.rx_dat  = 8'h00;
        bus_b.rx_stb  = 1'b0;
        bus_b.rx_err  = 1'b0;
        bus_b.rd      = 1'b0;
        bus_b.clr_err = 1'b0;
        cycle(3);
        check_reset_state("reset");

        // Strobe already high as reset releases, held four clocks: one push only.
        $display("[TB] strobe held across reset release");
        reset        = 1'b0;
        bus_a.rx_dat = 8'h41;
        bus_a.rx_stb = 1'b1;
        q_a.push_back(8'h41);
        cycle(4);
        check_output("held_level", bus_a.rx_level, 1);
        check_output("held_rd_dat", bus_a.rd_dat, 8'h41);
        check_output("held_irq", bus_a.rx_irq, 1'b1);
        check_output("held_avail", bus_a.rx_avail, 1'b1);
        bus_a.rx_stb = 1'b0;
        cycle();
        pop_a("held_pop");
        check_output("held_empty_level", bus_a.rx_level, 0);
        check_output("held_empty_rd_dat", bus_a.rd_dat, 8'h00);
        check_output("held_empty_irq", bus_a.rx_irq, 1'b0);

        $display("[TB] fill to full then overrun");
        for (int i = 0; i < 16; i++)
            apply_stimulus_a(8'(i), 1'b1);
        check_output("full_level", bus_a.rx_level, 16);
        check_output("full_no_ovr", bus_a.rx_ovr, 1'b0);
        apply_stimulus_a(8'hAA, 1'b0);
        check_output("ovr_level", bus_a.rx_level, 16);
        check_output("ovr_flag", bus_a.rx_ovr, 1'b1);
        check_output("ovr_irq", bus_a.rx_irq, 1'b1);
        for (int i = 0; i < 16; i++)
            pop_a("ovr_drain");
        check_output("ovr_drained_level", bus_a.rx_level, 0);
        check_output("ovr_sticky", bus_a.rx_ovr, 1'b1);
        bus_a.clr_err = 1'b1;
        cycle();
        bus_a.clr_err = 1'b0;
        check_output("ovr_cleared", bus_a.rx_ovr, 1'b0);
        check_output("ovr_cleared_irq", bus_a.rx_irq, 1'b0);

        $display("[TB] full with simultaneous push and pop");
        for (int i = 0; i < 16; i++)
            apply_stimulus_a(8'h10 + 8'(i), 1'b1);
        check_output("simul_full_level", bus_a.rx_level, 16);
        check_output("simul_head", bus_a.rd_dat, q_a[0]);
        void'(q_a.pop_front());
        q_a.push_back(8'h55);
        bus_a.rx_dat = 8'h55;
        bus_a.rx_stb = 1'b1;
        bus_a.rd     = 1'b1;
        cycle();
        bus_a.rx_stb = 1'b0;
        bus_a.rd     = 1'b0;
        check_output("simul_level", bus_a.rx_level, 16);
        check_output("simul_no_ovr", bus_a.rx_ovr, 1'b0);
        check_output("simul_next_head", bus_a.rd_dat, 8'h11);
        cycle();
        for (int i = 0; i < 16; i++)
            pop_a("simul_drain");
        check_output("simul_drained_level", bus_a.rx_level, 0);

        $display("[TB] pop while empty");
        bus_a.rd = 1'b1;
        cycle();
        bus_a.rd = 1'b0;
        check_output("empty_rd_level", bus_a.rx_level, 0);
        check_output("empty_rd_dat", bus_a.rd_dat, 8'h00);
        check_output("empty_rd_avail", bus_a.rx_avail, 1'b0);
        q_a.push_back(8'h33);
        bus_a.rx_dat = 8'h33;
        bus_a.rx_stb = 1'b1;
        bus_a.rd     = 1'b1;
        cycle();
        bus_a.rx_stb = 1'b0;
        bus_a.rd     = 1'b0;
        check_output("empty_push_level", bus_a.rx_level, 1);
        check_output("empty_push_rd_dat", bus_a.rd_dat, 8'h33);
        cycle();
        pop_a("empty_push_pop");
        check_output("empty_push_drained", bus_a.rx_level, 0);

        $display("[TB] framing error flag");
        bus_a.rx_err = 1'b1;
        cycle(10);
        check_output("ferr_set", bus_a.rx_ferr, 1'b1);
        check_output("ferr_irq", bus_a.rx_irq, 1'b1);
        check_output("ferr_level", bus_a.rx_level, 0);
        bus_a.rx_err  = 1'b0;
        bus_a.clr_err = 1'b1;
        cycle();
        bus_a.clr_err = 1'b0;
        check_output("ferr_cleared", bus_a.rx_ferr, 1'b0);
        check_output("ferr_cleared_irq", bus_a.rx_irq, 1'b0);
        bus_a.rx_err  = 1'b1;
        bus_a.clr_err = 1'b1;
        cycle();
        bus_a.clr_err = 1'b0;
        check_output("ferr_set_beats_clr", bus_a.rx_ferr, 1'b1);
        bus_a.rx_err = 1'b0;
        cycle();
        check_output("ferr_still_sticky", bus_a.rx_ferr, 1'b1);

        $display("[TB] interrupt threshold of four");
        for (int i = 0; i < 3; i++)
            apply_stimulus_b(8'hC0 + 8'(i));
        check_output("thr_level3", bus_b.rx_level, 3);
        check_output("thr_irq_below", bus_b.rx_irq, 1'b0);
        apply_stimulus_b(8'hC3);
        check_output("thr_level4", bus_b.rx_level, 4);
        check_output("thr_irq_at", bus_b.rx_irq, 1'b1);
        check_output("thr_head", bus_b.rd_dat, q_b.pop_front());
        bus_b.rd = 1'b1;
        cycle();
        bus_b.rd = 1'b0;
        check_output("thr_irq_drop", bus_b.rx_irq, 1'b0);
        check_output("thr_next_head", bus_b.rd_dat, q_b[0]);

        // Reset lands while a new byte is being strobed into both instances.
        bus_b.rx_dat = 8'h99;
        bus_b.rx_stb = 1'b1;
        bus_a.rx_dat = 8'h77;
        bus_a.rx_stb = 1'b1;
        reset        = 1'b1;
        cycle();
        check_reset_state("midreset");
        q_a.delete();
        q_b.delete();
        bus_a.rx_stb = 1'b0;
        bus_b.rx_stb = 1'b0;
        reset        = 1'b0;
        cycle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
